// File: rtl/node_injector.sv
// Local-port flit source: packet requests plus a payload stream in, labelled flits out to a router LOCAL port.
// Head visible 2 cycles after accept, then one flit per cycle; stalls on per-VC on/off and on missing payload.
package noc_params;
  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE   = 16;
  localparam int HEAD_PL_SIZE     = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [HEAD_PL_SIZE-1:0]     head_pl;
  } head_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } data;
  } flit_t;
endpackage

module node_injector
  import noc_params::*;
#(
  parameter  int MAX_PKT_LEN = 8,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0] req_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] req_y_dest_i,
  input  logic [LEN_W-1:0]            req_len_i,
  input  logic                        payload_valid_i,
  output logic                        payload_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]   payload_i,
  output flit_t                       data_o,
  output logic                        is_valid_o,
  input  logic [VC_NUM-1:0]           is_on_off_i,
  input  logic [VC_NUM-1:0]           is_allocatable_i,
  output logic                        busy_o,
  output logic                        pkt_sent_o
);

  typedef enum logic [1:0] {IDLE, VC_SEL, SEND} state_t;

  state_t                      r_state, w_state_n;
  logic [DEST_ADDR_SIZE_X-1:0] r_x;
  logic [DEST_ADDR_SIZE_Y-1:0] r_y;
  logic [LEN_W-1:0]            r_len, r_remaining, w_len;
  logic [VC_SIZE-1:0]          r_vc, r_rr, w_pick;
  logic [VC_NUM-1:0]           w_elig;
  logic                        w_found, w_fire, w_emit, w_tail;
  flit_t                       w_flit, r_data;
  logic                        r_valid, r_sent;

  assign w_len  = (req_len_i == '0) ? LEN_W'(1) :
                  (req_len_i > LEN_W'(MAX_PKT_LEN)) ? LEN_W'(MAX_PKT_LEN) : req_len_i;
  assign w_elig = is_allocatable_i & is_on_off_i;
  assign w_fire = is_on_off_i[r_vc] & payload_valid_i;
  assign busy_o = (r_state != IDLE);

  // First eligible VC scanning upward from the round-robin pointer.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(r_rr) + i) % VC_NUM;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = VC_SIZE'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n       = r_state;
    w_emit          = 1'b0;
    w_tail          = 1'b0;
    w_flit          = '0;
    req_ready_o     = 1'b0;
    payload_ready_o = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_n = VC_SEL;
      end
      VC_SEL: begin
        if (w_found) begin
          w_emit                       = 1'b1;
          w_flit.vc_id                 = w_pick;
          w_flit.data.head_data.x_dest = r_x;
          w_flit.data.head_data.y_dest = r_y;
          if (r_len == LEN_W'(1)) begin
            w_flit.flit_label = HEADTAIL;
            w_tail            = 1'b1;
            w_state_n         = IDLE;
          end else begin
            w_flit.flit_label = HEAD;
            w_state_n         = SEND;
          end
        end
      end
      SEND: begin
        if (w_fire) begin
          payload_ready_o   = 1'b1;
          w_emit            = 1'b1;
          w_flit.vc_id      = r_vc;
          w_flit.data.bt_pl = payload_i;
          if (r_remaining == LEN_W'(1)) begin
            w_flit.flit_label = TAIL;
            w_tail            = 1'b1;
            w_state_n         = IDLE;
          end else begin
            w_flit.flit_label = BODY;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_vc        <= '0;
      r_rr        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sent      <= 1'b0;
    end else begin
      r_data  <= w_flit;
      r_valid <= w_emit;
      r_sent  <= w_tail;
      if (r_state == IDLE && req_valid_i) begin
        r_x   <= req_x_dest_i;
        r_y   <= req_y_dest_i;
        r_len <= w_len;
      end
      // VC is chosen once and held until the tail leaves.
      if (r_state == VC_SEL && w_found) begin
        r_vc        <= w_pick;
        r_rr        <= VC_SIZE'((int'(w_pick) + 1) % VC_NUM);
        r_remaining <= r_len - LEN_W'(1);
      end
      if (r_state == SEND && w_fire) r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign data_o     = r_data;
  assign is_valid_o = r_valid;
  assign pkt_sent_o = r_sent;

endmodule

// File: doc/node_injector.md
# node_injector

Local-port traffic source for a mesh node. It turns packet requests (destination plus flit count) and a body-payload stream into `flit_t` flits and drives them into a router's local input port. It picks a downstream VC, honours the router's per-VC on/off back-pressure, and labels flits HEAD/BODY/TAIL/HEADTAIL. It sits between a core-side traffic generator and router port LOCAL, the transmit end of the router's `data_in`/`is_valid_in`/`is_on_off_out`/`is_allocatable_out` link.

## Interface
- `MAX_PKT_LEN`, default 8: maximum flits per packet; `LEN_W = $clog2(MAX_PKT_LEN+1)`.
- `VC_NUM`, `DEST_ADDR_SIZE_X`, `DEST_ADDR_SIZE_Y`, `flit_t`: come from `noc_params`; not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  packet request valid.
- `req_ready_o`  out  1  request accepted when both valid and ready are high.
- `req_x_dest_i`  in  DEST_ADDR_SIZE_X  destination x.
- `req_y_dest_i`  in  DEST_ADDR_SIZE_Y  destination y.
- `req_len_i`  in  LEN_W  packet length in flits.
- `payload_valid_i`  in  1  body/tail payload word valid.
- `payload_ready_o`  out  1  payload word consumed this cycle.
- `payload_i`  in  body payload width of `flit_t`  payload for BODY/TAIL flits.
- `data_o`  out  flit_t  flit to router `data_in[LOCAL]`.
- `is_valid_o`  out  1  `data_o` valid, one cycle per flit.
- `is_on_off_i`  in  VC_NUM  router `is_on_off_out[LOCAL]`; 1 = VC may receive.
- `is_allocatable_i`  in  VC_NUM  router `is_allocatable_out[LOCAL]`; 1 = VC idle.
- `busy_o`  out  1  high from request accept to tail emission.
- `pkt_sent_o`  out  1  one-cycle pulse, coincident with tail/headtail on `is_valid_o`.

## Operation
- States: IDLE, VC_SEL, SEND.
- **IDLE**
  - `req_ready_o` = 1.
  - On accept, latch destination and length, then go to VC_SEL.
  - Length rules: `req_len_i` of 0 is treated as 1; values above MAX_PKT_LEN are clamped to MAX_PKT_LEN.
- **VC_SEL**
  - Eligible VC: `is_allocatable_i[v] & is_on_off_i[v]`.
  - Round-robin pick starting at pointer `rr_q`.
  - If none is eligible, stay in VC_SEL with no output.
  - On a pick:
    - Latch `vc_q`; set `rr_q` to pick+1 mod VC_NUM.
    - Emit the first flit: HEADTAIL if length = 1, otherwise HEAD.
    - The head carries `x_dest`/`y_dest` and `vc_id = vc_q`. It consumes no payload.
  - Next state: IDLE if length = 1, else SEND.
- **SEND**
  - A flit fires when `is_on_off_i[vc_q] & payload_valid_i`.
  - `payload_ready_o` equals fire; the fired flit carries `payload_i` and `vc_id = vc_q`.
  - `remaining` counts down from length-1. Label is TAIL when `remaining` = 1, otherwise BODY.
  - After the tail fires, go to IDLE.
- VC hold: `is_allocatable_i` is sampled only in VC_SEL; the VC is held until the tail.
- Mid-packet stall: `is_on_off_i[vc_q]` low stalls without loss. No payload is consumed while stalled.
- `busy_o` = state != IDLE.
- Simultaneous events: `req_valid_i` in a non-IDLE state is ignored (ready is low). Both payload valid and on/off must be high for a flit to fire.

## Timing
- `data_o`, `is_valid_o` and `pkt_sent_o` are registered. A flit decided in cycle t is visible in cycle t+1.
- `req_ready_o`, `payload_ready_o` and `busy_o` are combinational from state and inputs.
- Minimum latency: request accepted at t gives the head on `is_valid_o` at t+2 (VC free).
- Throughput: one flit per cycle. An N-flit packet occupies N+1 cycles from VC_SEL entry with no stalls. The next request is accepted the cycle after the tail is decided.
- Reset (async, any time including mid-packet):
  - State becomes IDLE; `rr_q`, `vc_q` and `remaining` become 0.
  - `is_valid_o`, `pkt_sent_o` and `data_o` become 0.
  - `req_ready_o` is 1 after reset; `busy_o` and `payload_ready_o` are 0.
  - A partial packet is abandoned; no tail is generated.
- On/off latency: the router's on/off threshold covers the one-cycle output register. The block does not count credits.

## Test plan
- Reset, then request (x=2, y=1, len=1) with all VCs free → one HEADTAIL, dest (2,1), vc 0, at t+2; `pkt_sent_o` pulses with it; no payload consumed.
- Request len=4, payloads 0xA,0xB,0xC → HEAD, BODY 0xA, BODY 0xB, TAIL 0xC on 4 consecutive cycles, same vc_id; `busy_o` high across.
- Three back-to-back len=2 packets, all VCs eligible → vc_ids 0,1,2 (round robin); with only VC 1 allocatable → all on VC 1.
- `is_on_off_i[vc_q]` low for 3 cycles mid-packet, then high → flit stream pauses 3 cycles, no duplicated or dropped payload, `payload_ready_o` low while stalled.
- `req_len_i`=0 → HEADTAIL; `req_len_i`=MAX_PKT_LEN+3 → exactly MAX_PKT_LEN flits.
- Assert `rst` low during BODY of a len=6 packet → `is_valid_o` 0 immediately, `req_ready_o` 1 after release, next packet starts with HEAD on vc 0.
